// File: rtl/note_pkg.sv
// Shared constants for the MIDI note to tone-period path: base-octave table, widths, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package note_pkg;

    localparam int NOTE_SEMIS = 12;
    localparam int MIDI_MAX   = 127;
    localparam int MIDI_W     = 7;
    localparam int OCT_W      = 4;
    localparam int BASE_W     = 10;

    // Half-period counts for C..B of the reference octave.
    localparam logic [BASE_W-1:0] BASE_TABLE [NOTE_SEMIS] = '{
        10'd682, 10'd644, 10'd608, 10'd574, 10'd542, 10'd512,
        10'd482, 10'd456, 10'd430, 10'd406, 10'd384, 10'd362
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Table lookup by semitone; out-of-range semitones (12..15) return 0.
    function automatic logic [BASE_W-1:0] base_lookup(input logic [3:0] semi);
        logic [BASE_W-1:0] b;
        b = '0;
        for (int i = 0; i < NOTE_SEMIS; i++) begin
            if (semi == 4'(i)) begin
                b = BASE_TABLE[i];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/note_scale.sv
// Octave scaling of a base-octave half-period by shifting, with saturation to BW bits.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//   base  : base-octave half-period (BASE_W bits)
//   oct   : octave index of the note
//   p     : scaled half-period, all ones when saturated
//   sat   : scaled value exceeded 2^BW-1
module note_scale
    import note_pkg::*;
#(
    parameter int BW      = 16,
    parameter int REF_OCT = 5
) (
    input  logic [BASE_W-1:0] base,
    input  logic [OCT_W-1:0]  oct,
    output logic [BW-1:0]     p,
    output logic              sat
);

    // Wide enough for the base shifted left by the full REF_OCT distance.
    localparam int WIDE_W = 16 + REF_OCT;
    localparam logic [WIDE_W-1:0] P_MAX = WIDE_W'((64'd1 << BW) - 64'd1);

    logic [WIDE_W-1:0] base_w;
    logic [WIDE_W-1:0] wide;

    assign base_w = WIDE_W'(base);

    always_comb begin
        wide = '0;
        if (int'(oct) < REF_OCT) begin
            // Lower octaves are longer periods: multiply by 2 per octave.
            wide = base_w << (REF_OCT - int'(oct));
        end else begin
            // Higher octaves halve the period per octave, truncating.
            wide = base_w >> (int'(oct) - REF_OCT);
        end
    end

    assign sat = (wide > P_MAX);
    assign p   = sat ? '1 : wide[BW-1:0];

endmodule

// File: rtl/note2period.sv
// Converts a MIDI note (0..127) into a tone-counter half-period via repeated-subtract octave split and shift scaling.
// Latency: period_valid_o rises 2+note/12 edges after the input handshake edge.
// Backpressure: one note in flight; note_ready_o stays low until the result is taken with period_ready_i.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   note_i/note_valid_i/note_ready_o : note input handshake
//   transpose_i                 : signed semitone offset, only with NOTE2PERIOD_TRANSPOSE_EN defined
//   period_o/octave_o/sat_o     : registered result, held after the output handshake
//   period_valid_o/period_ready_i : result handshake
module note2period
    import note_pkg::*;
#(
    parameter int BW      = 16,
    parameter int REF_OCT = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [MIDI_W-1:0] note_i,
    input  logic              note_valid_i,
    output logic              note_ready_o,
`ifdef NOTE2PERIOD_TRANSPOSE_EN
    input  logic signed [4:0] transpose_i,
`endif
    output logic [BW-1:0]     period_o,
    output logic [OCT_W-1:0]  octave_o,
    output logic              sat_o,
    output logic              period_valid_o,
    input  logic              period_ready_i
);

    state_t            state_q, state_d;
    logic [MIDI_W-1:0] rem_q;
    logic [OCT_W-1:0]  oct_q;
    logic              fin_q;
    logic [MIDI_W-1:0] note_eff;
    logic [BW-1:0]     scaled_p;
    logic              scaled_sat;

`ifdef NOTE2PERIOD_TRANSPOSE_EN
    // 9-bit sum covers -16..142; bit 8 flags a negative result.
    logic [8:0] note_sum;
    assign note_sum = {2'b00, note_i} + {{4{transpose_i[4]}}, transpose_i};

    always_comb begin
        note_eff = note_sum[MIDI_W-1:0];
        if (note_sum[8]) begin
            note_eff = '0;
        end else if (note_sum[7]) begin
            note_eff = MIDI_W'(MIDI_MAX);
        end
    end
`else
    assign note_eff = note_i;
`endif

    note_scale #(
        .BW      (BW),
        .REF_OCT (REF_OCT)
    ) u_scale (
        .base (base_lookup(rem_q[3:0])),
        .oct  (oct_q),
        .p    (scaled_p),
        .sat  (scaled_sat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (note_valid_i)   state_d = DIV;
            DIV:     if (fin_q)          state_d = DONE;
            DONE:    if (period_ready_i) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    assign note_ready_o   = (state_q == IDLE);
    assign period_valid_o = (state_q == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            oct_q    <= '0;
            fin_q    <= 1'b0;
            period_o <= '0;
            octave_o <= '0;
            sat_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (note_valid_i) begin
                        rem_q <= note_eff;
                        oct_q <= '0;
                        fin_q <= 1'b0;
                    end
                end
                DIV: begin
                    // Once the semitone is known, rem/oct sit still for one cycle so the
                    // table lookup and shifter start from registers before the result is captured.
                    if (fin_q) begin
                        period_o <= scaled_p;
                        octave_o <= oct_q;
                        sat_o    <= scaled_sat;
                    end else if (rem_q >= MIDI_W'(NOTE_SEMIS)) begin
                        rem_q <= rem_q - MIDI_W'(NOTE_SEMIS);
                        oct_q <= oct_q + OCT_W'(1);
                    end else begin
                        fin_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_note2period.sv
module tb_note2period;

    localparam int REF_OCT = 5;

    typedef struct {
        int p16;
        int s16;
        int p12;
        int s12;
        int oct;
        int rise;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [6:0]  note;
    logic        note_valid;
    logic        note_ready;
    logic        note_ready12;
    logic signed [4:0] transpose;
    logic [15:0] period;
    logic [11:0] period12;
    logic [3:0]  octave;
    logic [3:0]  octave12;
    logic        sat;
    logic        sat12;
    logic        period_valid;
    logic        period_valid12;
    logic        period_ready;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_left = 0;
    int   hs_cyc = 0;
    bit   prev_v = 1'b0;
    exp_t q[$];
    int   base_t[12] = '{682, 644, 608, 574, 542, 512, 482, 456, 430, 406, 384, 362};

    note2period #(.BW(16), .REF_OCT(REF_OCT)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .note_i         (note),
        .note_valid_i   (note_valid),
        .note_ready_o   (note_ready),
`ifdef NOTE2PERIOD_TRANSPOSE_EN
        .transpose_i    (transpose),
`endif
        .period_o       (period),
        .octave_o       (octave),
        .sat_o          (sat),
        .period_valid_o (period_valid),
        .period_ready_i (period_ready)
    );

    note2period #(.BW(12), .REF_OCT(REF_OCT)) dut12 (
        .clk_i          (clk),
        .rst_i          (rst),
        .note_i         (note),
        .note_valid_i   (note_valid),
        .note_ready_o   (note_ready12),
`ifdef NOTE2PERIOD_TRANSPOSE_EN
        .transpose_i    (transpose),
`endif
        .period_o       (period12),
        .octave_o       (octave12),
        .sat_o          (sat12),
        .period_valid_o (period_valid12),
        .period_ready_i (period_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: octave and semitone by division, period by power-of-two scaling.
    function automatic exp_t model(input int n, input int tr, input int t);
        exp_t e;
        int eff, b, p;
        eff = n + tr;
        if (eff < 0)   eff = 0;
        if (eff > 127) eff = 127;
        e.oct = eff / 12;
        b = base_t[eff % 12];
        if (e.oct < REF_OCT) p = b * (1 << (REF_OCT - e.oct));
        else                 p = b / (1 << (e.oct - REF_OCT));
        e.s16  = (p > 65535) ? 1 : 0;
        e.p16  = (p > 65535) ? 65535 : p;
        e.s12  = (p > 4095) ? 1 : 0;
        e.p12  = (p > 4095) ? 4095 : p;
        e.rise = t + 2 + e.oct;
        return e;
    endfunction

    // Source holds note_valid until accepted; t_acc is the accepting edge's cycle count.
    task automatic send(input int n, input int tr, input bit expect_out, output int t_acc);
        int guard;
        @(negedge clk);
        note       = 7'(n);
        transpose  = 5'(tr);
        note_valid = 1'b1;
        guard = 0;
        while (!note_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!note_ready) begin
            chk("accept_timeout", int'(note_ready), 1);
            note_valid = 1'b0;
            t_acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        t_acc = cyc;
        if (expect_out) q.push_back(model(n, tr, t_acc));
        note_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    endtask

    // Monitor: owns period_ready, checks latency at the valid rise and outputs every valid cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (period_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", int'(period_valid), 0);
                end else begin
                    chk("latency", cyc, q[0].rise);
                    chk("valid12_rise", int'(period_valid12), 1);
                end
            end
            if (stall_left > 0 && period_valid) begin
                period_ready = 1'b0;
                stall_left--;
            end else begin
                period_ready = ($urandom_range(0, 3) != 0);
            end
            if (period_valid && q.size() > 0) begin
                chk("period",     int'(period),   q[0].p16);
                chk("octave",     int'(octave),   q[0].oct);
                chk("sat",        int'(sat),      q[0].s16);
                chk("period_bw12", int'(period12), q[0].p12);
                chk("sat_bw12",   int'(sat12),    q[0].s12);
                chk("ready_low_busy", int'(note_ready), 0);
                if (period_ready) begin
                    void'(q.pop_front());
                    hs_cyc = cyc + 1;
                end
            end
            prev_v = period_valid;
        end
    end

    initial begin
        int t;
        int tr;
        rst          = 1'b1;
        note         = '0;
        note_valid   = 1'b0;
        transpose    = '0;
        period_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_period",     int'(period),       0);
        chk("rst_octave",     int'(octave),       0);
        chk("rst_sat",        int'(sat),          0);
        chk("rst_valid",      int'(period_valid), 0);
        chk("rst_note_ready", int'(note_ready),   1);
        rst = 1'b0;

        // Directed notes across the range, including both extremes.
        send(60, 0, 1'b1, t);
        send(69, 0, 1'b1, t);
        send(72, 0, 1'b1, t);
        send(127, 0, 1'b1, t);
        send(0, 0, 1'b1, t);
        send(11, 0, 1'b1, t);
        send(12, 0, 1'b1, t);
        drain();

        // Long stall: second note held by the source must wait for the result handshake.
        stall_left = 20;
        send(50, 0, 1'b1, t);
        send(10, 0, 1'b1, t);
        chk("accept_after_hs", t, hs_cyc + 1);
        drain();

`ifdef NOTE2PERIOD_TRANSPOSE_EN
        send(60, 12, 1'b1, t);
        send(5, -16, 1'b1, t);
        send(120, 15, 1'b1, t);
        drain();
`endif

        // Reset while dividing note 100 aborts the conversion.
        send(100, 0, 1'b0, t);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_period",     int'(period),       0);
        chk("abort_octave",     int'(octave),       0);
        chk("abort_sat",        int'(sat),          0);
        chk("abort_valid",      int'(period_valid), 0);
        chk("abort_note_ready", int'(note_ready),   1);
        repeat (20) @(negedge clk);
        chk("abort_no_valid", int'(period_valid), 0);

        // Random notes with random consumer backpressure.
        for (int i = 0; i < 300; i++) begin
            tr = 0;
`ifdef NOTE2PERIOD_TRANSPOSE_EN
            tr = int'($urandom_range(0, 31)) - 16;
`endif
            send(int'($urandom_range(0, 127)), tr, 1'b1, t);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
